combo_lock_ctrl: RTL and testbench
==================================

// Module: combo_lock_ctrl
// PURPOSE
//  Sequencing controller for the board's 2-digit BCD code matcher: turns SW[7:0] + a KEY press into a
//  clocked lock with attempt counting, timed unlock/fail indication and a lockout after repeated misses.
//  Sits under DE1_SoC; the top maps SW[7:0]->code_in and KEY[0]->submit_n, and drives LEDR from outputs.
// PARAMETERS
//  CODE         8'h84   expected code; [7:4] = upper BCD digit (SW[7:4]), [3:0] = lower digit (SW[3:0])
//  MAX_TRIES    3       consecutive wrong codes that trigger lockout (1..15)
//  OPEN_CYCLES  100     cycles unlocked stays high after a correct code (>=1)
//  FAIL_CYCLES  50      cycles fail stays high after a wrong code (>=1)
//  LOCK_CYCLES  500     cycles locked_out stays high (>=1)
// PORTS
//  clk         in   1  system clock (CLOCK_50 at the top)
//  reset_n     in   1  synchronous, active-low reset
//  submit_n    in   1  raw KEY, active-low, asynchronous to clk, not debounced
//  code_in     in   8  candidate code {upper BCD, lower BCD}
//  unlocked    out  1  high while in OPEN
//  fail        out  1  high while in FAIL
//  locked_out  out  1  high while in LOCKOUT
//  fail_count  out  4  wrong codes since the last success/lockout/reset
// BEHAVIOUR
//  - Reset (reset_n low at a rising edge): state IDLE, all outputs 0, fail_count 0, timer 0,
//    press-detector flops set to 1 (released) so no press event follows reset release.
//  - Press event: submit_n through 2 sync flops plus a history flop; event = prev & ~sync (one-cycle
//    pulse per falling edge). A held key yields exactly one event; bounce yields one event per edge.
//  - Events are honoured only in IDLE; in all other states they are dropped, never queued.
//  - States (Moore, outputs decoded from registered state):
//    IDLE    : on event -> latch code_in into code_q, go CHECK.
//    CHECK   : one cycle. code_q==CODE -> OPEN, fail_count<=0, timer<=OPEN_CYCLES-1.
//              else if fail_count+1==MAX_TRIES -> LOCKOUT, fail_count<=MAX_TRIES, timer<=LOCK_CYCLES-1.
//              else -> FAIL, fail_count<=fail_count+1, timer<=FAIL_CYCLES-1.
//    OPEN/FAIL/LOCKOUT : timer decrements each cycle; at timer==0 -> IDLE. Each state is therefore held
//              exactly its *_CYCLES cycles. Leaving LOCKOUT clears fail_count to 0.
//  - Latency: counting the edge that first samples submit_n low as edge 1, code_in is latched at edge 3
//    and unlocked/fail/locked_out asserts at edge 4. code_in changes after edge 3 have no effect.
//  - Exactly one of unlocked/fail/locked_out high at any time, or none (IDLE, CHECK).
//  - Timer width = $clog2(max(OPEN_CYCLES, FAIL_CYCLES, LOCK_CYCLES)+1); no wrap: it is only loaded
//    in CHECK and only decrements while nonzero.
//  - Comparison is a full 8-bit equality; non-BCD inputs (e.g. 8'hFA) are simply wrong codes.
//  - Reset mid-operation (any state) aborts immediately to the reset values above, including lockout.
//  - reset_n has priority over every event and timer expiry in the same cycle.
// STRUCTURE
//  - Package lock_pkg: typedef enum logic [2:0] {IDLE, CHECK, OPEN, FAIL, LOCKOUT} lock_state_t;
//    localparam DEFAULT_CODE = 8'h84.
//  - Sub-module key_press_detect (clk, reset_n, key_n, press): 2-flop sync + history flop + edge pulse;
//    reused later for other KEY inputs. FSM, timer and fail counter stay in combo_lock_ctrl.
// TESTING  (bench params: OPEN_CYCLES=4, FAIL_CYCLES=2, LOCK_CYCLES=8, MAX_TRIES=3)
//  1 Reset: hold reset_n=0 3 cycles with submit_n=0 -> all outputs 0; release with submit_n=1
//    -> no event, outputs stay 0.
//  2 code_in=8'h84, submit_n low for 10 cycles -> unlocked rises at edge 4, high exactly 4 cycles,
//    fail_count=0, single event only (no second OPEN).
//  3 code_in=8'h48 pressed -> fail high 2 cycles, fail_count=1; second wrong press -> fail_count=2.
//  4 three wrong presses (8'h00) -> third gives locked_out high 8 cycles, fail_count=3; a press of
//    8'h84 during lockout is ignored; afterwards fail_count=0, and 8'h84 then unlocks.
//  5 Two wrong then 8'h84 -> unlocked, fail_count cleared to 0; next wrong -> fail_count=1 (no lockout).
//  6 Reset asserted on the 3rd cycle of LOCKOUT -> next cycle all outputs 0, state IDLE;
//    code_in changed to 8'h00 on edge 4 of a 8'h84 press -> still unlocks.

Source files
------------

// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lock_pkg
// Description : Shared types and constants for the combination lock
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

  // Controller states; outputs are decoded directly from these.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    FAIL    = 3'd3,
    LOCKOUT = 3'd4
  } lock_state_t;

  // Factory code: upper BCD digit 8, lower BCD digit 4.
  localparam logic [7:0] DEFAULT_CODE = 8'h84;

  // Largest of three cycle counts, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_detect.sv
`default_nettype none
// ============================================================================
// Module      : key_press_detect
// Description : Synchronises a raw active-low key and emits a one-cycle
//               pulse for every falling edge seen after synchronisation.
// Revision    : 1.0 - initial release
// ============================================================================
module key_press_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Two-flop synchroniser plus history flop; reset to "released" so no edge follows reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // High for exactly one cycle when the synchronised key goes from released to pressed.
  assign press = r_prev & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : combo_lock_ctrl
// Description : Two-digit BCD combination lock sequencer with timed
//               unlock/fail indication, miss counting and lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module combo_lock_ctrl
  import lock_pkg::*;
#(
  parameter logic [7:0] CODE        = DEFAULT_CODE,
  parameter int         MAX_TRIES   = 3,
  parameter int         OPEN_CYCLES = 100,
  parameter int         FAIL_CYCLES = 50,
  parameter int         LOCK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       submit_n,
  input  logic [7:0] code_in,
  output logic       unlocked,
  output logic       fail,
  output logic       locked_out,
  output logic [3:0] fail_count
);

  localparam int c_TIMER_W = $clog2(max3(OPEN_CYCLES, FAIL_CYCLES, LOCK_CYCLES) + 1);

  // Reload values: a state is held for its full cycle count including the
  // cycle in which the timer reads zero.
  localparam logic [c_TIMER_W-1:0] c_OPEN_LD = c_TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_FAIL_LD = c_TIMER_W'(FAIL_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_LOCK_LD = c_TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_ONE     = c_TIMER_W'(1);
  localparam logic [3:0]           c_TRIES   = 4'(MAX_TRIES);

  lock_state_t          r_state;
  lock_state_t          w_state_nxt;
  logic [7:0]           r_code;
  logic [7:0]           w_code_nxt;
  logic [c_TIMER_W-1:0] r_timer;
  logic [c_TIMER_W-1:0] w_timer_nxt;
  logic [3:0]           r_fail_count;
  logic [3:0]           w_fail_nxt;
  logic [3:0]           w_fail_inc;
  logic                 w_press;

  key_press_detect u_submit_detect (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (submit_n),
    .press   (w_press)
  );

  // Miss count after one more wrong code; cannot overflow because the count
  // never exceeds MAX_TRIES - 1 while a code is being checked.
  assign w_fail_inc = r_fail_count + 4'd1;

  // State, latched code, timer and miss counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_code       <= 8'h00;
      r_timer      <= '0;
      r_fail_count <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_code       <= w_code_nxt;
      r_timer      <= w_timer_nxt;
      r_fail_count <= w_fail_nxt;
    end
  end

  // Next-state logic: presses only count in IDLE, timed states count down to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_timer_nxt = r_timer;
    w_fail_nxt  = r_fail_count;
    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_code_nxt  = code_in;
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (r_code == CODE) begin
          w_state_nxt = OPEN;
          w_fail_nxt  = 4'd0;
          w_timer_nxt = c_OPEN_LD;
        end else if (w_fail_inc == c_TRIES) begin
          w_state_nxt = LOCKOUT;
          w_fail_nxt  = c_TRIES;
          w_timer_nxt = c_LOCK_LD;
        end else begin
          w_state_nxt = FAIL;
          w_fail_nxt  = w_fail_inc;
          w_timer_nxt = c_FAIL_LD;
        end
      end
      OPEN, FAIL: begin
        if (r_timer == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer - c_ONE;
        end
      end
      LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nxt = IDLE;
          w_fail_nxt  = 4'd0;
        end else begin
          w_timer_nxt = r_timer - c_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    unlocked   = 1'b0;
    fail       = 1'b0;
    locked_out = 1'b0;
    case (r_state)
      OPEN:    unlocked   = 1'b1;
      FAIL:    fail       = 1'b1;
      LOCKOUT: locked_out = 1'b1;
      default: ;
    endcase
  end

  assign fail_count = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_combo_lock_ctrl
// Description : Scoreboard bench for combo_lock_ctrl with a press-level
//               reference model and a decoupled output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_lock_ctrl;

  localparam int         OPEN_N = 4;
  localparam int         FAIL_N = 2;
  localparam int         LOCK_N = 8;
  localparam int         TRIES  = 3;
  localparam logic [7:0] KEY    = 8'h84;

  // Output kinds as {unlocked, fail, locked_out}
  localparam logic [2:0] K_OPEN = 3'b100;
  localparam logic [2:0] K_FAIL = 3'b010;
  localparam logic [2:0] K_LOCK = 3'b001;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       submit_n = 1'b1;
  logic [7:0] code_in  = 8'h00;
  logic       unlocked;
  logic       fail;
  logic       locked_out;
  logic [3:0] fail_count;

  combo_lock_ctrl #(
    .CODE        (KEY),
    .MAX_TRIES   (TRIES),
    .OPEN_CYCLES (OPEN_N),
    .FAIL_CYCLES (FAIL_N),
    .LOCK_CYCLES (LOCK_N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .submit_n   (submit_n),
    .code_in    (code_in),
    .unlocked   (unlocked),
    .fail       (fail),
    .locked_out (locked_out),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;
    int         start;
    int         dur;
    int         fc_in;
    int         fc_out;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: consecutive misses and first edge at which IDLE accepts a press.
  int   m_fails    = 0;
  int   idle_from  = 0;
  int   last_start = 0;
  bit   mon_active = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Press issued at a falling edge when the last rising edge was c: the
  // code is taken at edge c+3 if the lock is idle then, result shows at c+4.
  task automatic predict(input logic [7:0] code, input int c);
    exp_t e;
    if (c + 3 < idle_from) return;
    e.start = c + 4;
    if (code == KEY) begin
      e.kind = K_OPEN; e.dur = OPEN_N; e.fc_in = 0; e.fc_out = 0;
      m_fails = 0;
    end else if (m_fails + 1 == TRIES) begin
      e.kind = K_LOCK; e.dur = LOCK_N; e.fc_in = TRIES; e.fc_out = 0;
      m_fails = 0;
    end else begin
      m_fails = m_fails + 1;
      e.kind = K_FAIL; e.dur = FAIL_N; e.fc_in = m_fails; e.fc_out = m_fails;
    end
    idle_from  = e.start + e.dur + 1;
    last_start = e.start;
    sb.push_back(e);
  endtask

  // Hold the key low for 'hold' edges; code_in switches to 'late' after edge 3.
  task automatic press(input logic [7:0] code, input int hold, input int gap,
                       input logic [7:0] late);
    int n;
    @(negedge clk);
    submit_n = 1'b0;
    code_in  = code;
    predict(code, cyc);
    n = (hold > 3) ? hold : 3;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 3) code_in = late;
      if (i == hold) submit_n = 1'b1;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (cyc + 3 < idle_from && b < 200) begin
      @(negedge clk);
      b++;
    end
  endtask

  // Monitor: pops one expectation per output pulse and checks kind, start, length, count.
  initial begin
    logic [2:0] k;
    int         len;
    exp_t       e;
    len = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_active = 1'b0;
        continue;
      end
      k = {unlocked, fail, locked_out};
      chk("onehot_outputs", ($countones(k) <= 1) ? 1 : 0, 1);
      if (mon_active && k == e.kind) begin
        len++;
      end else begin
        if (mon_active) begin
          chk("pulse_length", len, e.dur);
          chk("fail_count_after", fail_count, e.fc_out);
          mon_active = 1'b0;
        end
        if (k != 3'b000) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", k, 0);
          end else begin
            e = sb.pop_front();
            chk("output_kind", k, e.kind);
            chk("start_edge", cyc, e.start);
            chk("fail_count_during", fail_count, e.fc_in);
            mon_active = 1'b1;
            len        = 1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rc;
    logic [7:0] rl;
    int         b;

    // Reset held with the key pressed, released with the key up: no event.
    reset_n  = 1'b0;
    submit_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_unlocked", unlocked, 0);
    chk("reset_fail", fail, 0);
    chk("reset_locked_out", locked_out, 0);
    chk("reset_fail_count", fail_count, 0);
    submit_n = 1'b1;
    reset_n  = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_event_after_reset", {unlocked, fail, locked_out}, 0);

    // Correct code with a long hold: one unlock only.
    press(KEY, 10, 2, KEY);
    wait_idle();

    // Two wrong codes.
    press(8'h48, 3, 1, 8'h48);
    wait_idle();
    press(8'h48, 2, 1, 8'h48);
    wait_idle();
    press(KEY, 4, 1, KEY);
    wait_idle();

    // Three misses -> lockout, a correct press during lockout is dropped.
    press(8'h00, 3, 1, 8'h00);
    wait_idle();
    press(8'h00, 3, 1, 8'h00);
    wait_idle();
    press(8'h00, 3, 1, 8'h00);
    press(KEY, 2, 1, KEY);
    wait_idle();
    press(KEY, 3, 1, KEY);
    wait_idle();

    // Two misses, a success clears the count, next miss is a plain fail.
    press(8'hFA, 3, 1, 8'hFA);
    wait_idle();
    press(8'h83, 3, 1, 8'h83);
    wait_idle();
    press(KEY, 3, 1, KEY);
    wait_idle();
    press(8'h48, 3, 1, 8'h48);
    wait_idle();

    // Two more misses reach lockout; reset on its third cycle.
    press(8'h11, 3, 1, 8'h11);
    wait_idle();
    press(8'h22, 1, 0, 8'h22);
    b = 0;
    while (cyc < last_start + 2 && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("lockout_before_reset", locked_out, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_unlocked", unlocked, 0);
    chk("abort_fail", fail, 0);
    chk("abort_locked_out", locked_out, 0);
    chk("abort_fail_count", fail_count, 0);
    sb.delete();
    m_fails   = 0;
    idle_from = 0;
    reset_n   = 1'b1;
    @(negedge clk);

    // Idle after reset with a cleared counter, and late code changes are ignored.
    press(8'h48, 3, 1, 8'h48);
    wait_idle();
    press(KEY, 6, 1, 8'h00);
    wait_idle();

    // Randomised presses, including ones that land while busy.
    for (int i = 0; i < 60; i++) begin
      rc = ($urandom_range(0, 2) == 0) ? KEY : 8'($urandom);
      rl = 8'($urandom);
      press(rc, $urandom_range(1, 12), $urandom_range(0, 14), rl);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end

    // Drain outstanding expectations.
    b = 0;
    while ((sb.size() != 0 || mon_active) && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("drain_queue", sb.size(), 0);
    chk("drain_active", mon_active ? 1 : 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
